// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit stages.
// Frame: one start bit, data bits LSB-first, then one or more stop bits.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultDepth      = 4;
  localparam int unsigned DefaultStopBits   = 2;
  localparam int unsigned DefaultClksPerBit = 16;

  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Counter width for a 0..v-1 range, never narrower than one bit.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so that an idle line cannot produce a false start.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: mid-bit sampling, framing-error detection and a
// history buffer of the last DEPTH good bytes ([0] is the newest entry).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned STOP_BITS    = DefaultStopBits,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               RXserial,
  input  logic                               buf_clear,
  output logic [WIDTH-1:0]                   data,
  output logic                               rx_valid,
  output logic                               frame_err,
  output logic                               busy,
  output logic [$clog2(DEPTH+1)-1:0]         rx_count,
  output logic [DEPTH-1:0][WIDTH-1:0]        RXBUF
);

  localparam int unsigned HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W    = clog2_min1(CLKS_PER_BIT);
  localparam int unsigned BIT_W    = clog2_min1((WIDTH > STOP_BITS) ? WIDTH : STOP_BITS);
  localparam int unsigned CNT_RX_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]    HALF_M1   = CNT_W'((HALF == 0) ? 0 : HALF - 1);
  localparam logic [CNT_W-1:0]    CPB_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]    LAST_DATA = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]    LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_RX_W-1:0] FULL      = CNT_RX_W'(DEPTH);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RXserial),
    .q     (rx_s)
  );

  rx_state_t                   state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [WIDTH-1:0]            shift_q, shift_d;
  logic                        err_q, err_d;
  logic                        armed_q, armed_d;
  logic                        done_ok, done_bad, stop_bad;

  logic [WIDTH-1:0]            data_q, data_d;
  logic [DEPTH-1:0][WIDTH-1:0] buf_q, buf_d;
  logic [CNT_RX_W-1:0]         count_q, count_d;
  logic                        valid_q, ferr_q;

  // Frame FSM and sampling counters.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    err_d    = err_q;
    armed_d  = armed_q;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    stop_bad = err_q | (rx_s != STOP_LEVEL);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s == STOP_LEVEL) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          err_d = 1'b0;
          bit_d = '0;
          // With HALF == 0 this edge is already the start-bit sample.
          state_d = (HALF == 0) ? DATA : START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = (rx_s == START_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d            = '0;
          shift_d          = shift_q >> 1;
          shift_d[WIDTH-1] = rx_s;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          err_d = stop_bad;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = IDLE;
            // A line left low (break) must go high before the next start.
            armed_d  = rx_s;
            done_ok  = !stop_bad;
            done_bad = stop_bad;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion: data, history buffer and fill count.
  always_comb begin
    data_d  = data_q;
    buf_d   = buf_q;
    count_d = count_q;
    if (done_ok) begin
      data_d   = shift_q;
      buf_d[0] = shift_q;
      for (int i = 1; i < int'(DEPTH); i++) begin
        buf_d[i] = buf_q[i-1];
      end
      count_d = (count_q == FULL) ? count_q : count_q + CNT_RX_W'(1);
    end
    if (buf_clear) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      data_q  <= '0;
      buf_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      valid_q <= done_ok;
      ferr_q  <= done_bad;
    end
  end

  assign data      = data_q;
  assign RXBUF     = buf_q;
  assign rx_count  = count_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a 16x-oversampled instance and a
// one-clock-per-bit instance fed by back-to-back frames.
module tb_uart_receiver;

  logic             clk;
  logic             reset;
  logic             buf_clear;
  logic             RXserial;
  logic             RXserial_lb;

  logic [7:0]       data, data_lb;
  logic             rx_valid, rx_valid_lb;
  logic             frame_err, frame_err_lb;
  logic             busy, busy_lb;
  logic [2:0]       rx_count, rx_count_lb;
  logic [3:0][7:0]  RXBUF, RXBUF_lb;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  int busy_cnt = 0;
  int lb_ecnt = 0;
  logic [7:0] lb_q[$];

  uart_receiver #(
    .WIDTH        (8),
    .DEPTH        (4),
    .STOP_BITS    (2),
    .CLKS_PER_BIT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RXserial  (RXserial),
    .buf_clear (buf_clear),
    .data      (data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .rx_count  (rx_count),
    .RXBUF     (RXBUF)
  );

  uart_receiver #(
    .WIDTH        (8),
    .DEPTH        (4),
    .STOP_BITS    (2),
    .CLKS_PER_BIT (1)
  ) dut_lb (
    .clk       (clk),
    .reset     (reset),
    .RXserial  (RXserial_lb),
    .buf_clear (buf_clear),
    .data      (data_lb),
    .rx_valid  (rx_valid_lb),
    .frame_err (frame_err_lb),
    .busy      (busy_lb),
    .rx_count  (rx_count_lb),
    .RXBUF     (RXBUF_lb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)    vcnt++;
    if (frame_err)   ecnt++;
    if (busy)        busy_cnt++;
    if (rx_valid_lb) lb_q.push_back(data_lb);
    if (frame_err_lb) lb_ecnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    RXserial = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] stops);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    for (int j = 0; j < 2; j++) drive_bit(stops[j], 16);
    RXserial = 1'b1;
    idle(20);
  endtask

  task automatic send_lb(input logic [7:0] b);
    RXserial_lb = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXserial_lb = b[i];
      @(negedge clk);
    end
    repeat (2) begin
      RXserial_lb = 1'b1;
      @(negedge clk);
    end
  endtask

  logic [7:0] lb_exp [4];
  int busy_before;

  initial begin
    lb_exp[0] = 8'h01; lb_exp[1] = 8'h80; lb_exp[2] = 8'hFF; lb_exp[3] = 8'h00;
    reset       = 1'b0;
    buf_clear   = 1'b0;
    RXserial    = 1'b1;
    RXserial_lb = 1'b1;
    idle(3);
    check("reset_data", 32'(data), 32'h0);
    check("reset_count", 32'(rx_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rxbuf", RXBUF, 32'h0);
    reset = 1'b1;
    idle(5);

    // Good frame.
    send_frame(8'hA5, 2'b11);
    check("a5_valid_cnt", 32'(vcnt), 32'd1);
    check("a5_err_cnt", 32'(ecnt), 32'd0);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_rxbuf0", 32'(RXBUF[0]), 32'hA5);
    check("a5_count", 32'(rx_count), 32'd1);

    // Short low glitch on an idle line.
    busy_before = busy_cnt;
    drive_bit(1'b0, 5);
    RXserial = 1'b1;
    idle(30);
    check("glitch_busy_seen", 32'(busy_cnt != busy_before), 32'd1);
    check("glitch_busy_now", 32'(busy), 32'd0);
    check("glitch_valid_cnt", 32'(vcnt), 32'd1);
    check("glitch_err_cnt", 32'(ecnt), 32'd0);
    check("glitch_data", 32'(data), 32'hA5);

    // Second stop bit low: framing error, state preserved.
    send_frame(8'h3C, 2'b01);
    idle(20);
    check("bad_err_cnt", 32'(ecnt), 32'd1);
    check("bad_valid_cnt", 32'(vcnt), 32'd1);
    check("bad_data", 32'(data), 32'hA5);
    check("bad_rxbuf", RXBUF, 32'h0000_00A5);
    check("bad_count", 32'(rx_count), 32'd1);

    // Fill past DEPTH; count saturates.
    send_frame(8'h11, 2'b11);
    check("fill_count_2", 32'(rx_count), 32'd2);
    send_frame(8'h22, 2'b11);
    send_frame(8'h33, 2'b11);
    send_frame(8'h44, 2'b11);
    send_frame(8'h55, 2'b11);
    check("fill_valid_cnt", 32'(vcnt), 32'd6);
    check("fill_count_sat", 32'(rx_count), 32'd4);
    check("fill_rxbuf", RXBUF, 32'h2233_4455);
    check("fill_data", 32'(data), 32'h55);

    buf_clear = 1'b1;
    @(negedge clk);
    buf_clear = 1'b0;
    check("clear_count", 32'(rx_count), 32'd0);
    check("clear_rxbuf", RXBUF, 32'h0);
    check("clear_data", 32'(data), 32'h55);

    // Reset in the middle of data bit 3.
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    RXserial = 1'b1;
    idle(40);
    check("abort_valid_cnt", 32'(vcnt), 32'd6);
    check("abort_err_cnt", 32'(ecnt), 32'd1);
    check("abort_data", 32'(data), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    send_frame(8'h7E, 2'b11);
    check("resume_valid_cnt", 32'(vcnt), 32'd7);
    check("resume_data", 32'(data), 32'h7E);
    check("resume_count", 32'(rx_count), 32'd1);

    // One clock per bit, frames back-to-back with no idle gap.
    idle(3);
    send_lb(8'h01);
    send_lb(8'h80);
    send_lb(8'hFF);
    send_lb(8'h00);
    RXserial_lb = 1'b1;
    idle(20);
    check("lb_valid_cnt", 32'(lb_q.size()), 32'd4);
    for (int i = 0; i < lb_q.size() && i < 4; i++) begin
      check($sformatf("lb_byte%0d", i), 32'(lb_q[i]), 32'(lb_exp[i]));
    end
    check("lb_rxbuf", RXBUF_lb, 32'h0180_FF00);
    check("lb_count", 32'(rx_count_lb), 32'd4);
    check("lb_err_cnt", 32'(lb_ecnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
